param_updown_counter: RTL and testbench
=======================================

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning counter width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MODULUS, default 16, meaning count range 0..MODULUS-1 (legal range 2..2**WIDTH).
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, meaning synchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit, meaning count enable; it is also the cascade-in from a lower stage's tc.
REQ-006 The block SHALL have port up, input, 1 bit, meaning count direction (1 = up, 0 = down).
REQ-007 The block SHALL have port load, input, 1 bit, meaning a synchronous load strobe.
REQ-008 The block SHALL have port d, input, WIDTH bits, meaning the load value.
REQ-009 The block SHALL have port q, output, WIDTH bits, meaning the registered count.
REQ-010 The block SHALL have port tc, output, 1 bit, meaning terminal count / cascade-out (combinational).

Function
REQ-011 q SHALL update one cycle after the qualifying edge; there SHALL be no other latency.
REQ-012 Priority on each rising edge SHALL be reset > load > en; with none asserted, q SHALL hold.
REQ-013 When load is asserted, q SHALL take d if d < MODULUS, else MODULUS-1 (clamp); en and up SHALL be ignored that cycle.
REQ-014 When en=1 and up=1, q SHALL increment by 1, and q = MODULUS-1 SHALL wrap to 0.
REQ-015 When en=1 and up=0, q SHALL decrement by 1, and q = 0 SHALL wrap to MODULUS-1.
REQ-016 tc SHALL equal en & ~load & (up ? q==MODULUS-1 : q==0), so that it is high exactly in the cycle before a wrap.
REQ-017 Changing up while en=1 SHALL take effect on the same edge with no dead cycle.
REQ-018 Chaining stages (tc of stage N driving en of stage N+1, with shared clk, reset and up) SHALL form a synchronous multi-digit counter with no ripple delay between stages.
REQ-019 Arithmetic SHALL be computed WIDTH+1 bits wide internally; q SHALL never hold a value >= MODULUS.

Reset
REQ-020 When reset=1 at a rising clk edge, q SHALL become 0, regardless of load and en.
REQ-021 tc SHALL be 0 while reset is asserted.
REQ-022 Reset asserted mid-count SHALL abort the count, and counting SHALL resume from 0 on the first enabled edge after deassertion.
REQ-023 The block SHALL have no asynchronous reset path.

Configuration
REQ-024 The macro COUNTER_SATURATE_EN SHALL select the limit behaviour at compile time.
REQ-025 With COUNTER_SATURATE_EN undefined, the block SHALL wrap per REQ-014/015.
REQ-026 With COUNTER_SATURATE_EN defined, counting up SHALL hold at MODULUS-1 and counting down SHALL hold at 0.
REQ-027 With COUNTER_SATURATE_EN defined, tc SHALL still follow REQ-016, remaining high while en holds the counter at its limit.

Structure
REQ-028 The shared package counter_pkg SHALL hold the direction constants (DIR_UP = 1, DIR_DOWN = 0) and the default WIDTH/MODULUS constants.
REQ-029 The block SHALL be a single module with no sub-modules; the next-state and tc logic are too small to warrant one.

Verification
REQ-030 With WIDTH=4 and MODULUS=10, reset, then en=1, up=1 for 12 cycles -> q SHALL run 0..9,0,1, and tc SHALL be high only while q=9.
REQ-031 With MODULUS=10, load d=3, then en=1, up=0 for 5 cycles -> q SHALL run 3,2,1,0,9,8, and tc SHALL be high only while q=0.
REQ-032 With MODULUS=10, load d=12 -> q SHALL be 9 (clamp).
REQ-033 With MODULUS=10, load=1, en=1 and reset=1 on the same edge -> q SHALL be 0; with load=1, en=1 and d=5 (reset low) -> q SHALL be 5.
REQ-034 Chain two stages (MODULUS=10 each) and count up 25 cycles from reset -> {q_hi, q_lo} SHALL be 2,5.
REQ-035 With COUNTER_SATURATE_EN defined and MODULUS=10, count up 15 cycles from reset -> q SHALL hold at 9, and tc SHALL stay high while en=1.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter family: direction encodings
// and the default width/modulus used when a counter is not parameterised.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int unsigned     DEFAULT_WIDTH   = 4;
    localparam longint unsigned DEFAULT_MODULUS = 16;

endpackage

// File: rtl/param_updown_counter.sv
// Modulo-N up/down counter with synchronous load and cascadable terminal count.
// q counts 0..MODULUS-1. tc is combinational, so it can drive the en of the
// next stage and advance that stage on the same edge, with no ripple delay.
// Compile-time option: define COUNTER_SATURATE_EN to hold at the limits
// instead of wrapping. tc still flags the limit while en is high.
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH   = DEFAULT_WIDTH,
    parameter longint unsigned MODULUS = DEFAULT_MODULUS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    // Arithmetic is one bit wider than q. This lets MODULUS == 2**WIDTH be
    // represented, and lets a load value be compared against it directly.
    localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] LAST    = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ZERO    = '0;
    localparam logic [WIDTH:0] ONE     = (WIDTH+1)'(1);

`ifdef COUNTER_SATURATE_EN
    localparam logic [WIDTH:0] AFTER_LAST = LAST;
    localparam logic [WIDTH:0] AFTER_ZERO = ZERO;
`else
    localparam logic [WIDTH:0] AFTER_LAST = ZERO;
    localparam logic [WIDTH:0] AFTER_ZERO = LAST;
`endif

    // Out-of-range load values clamp to the top of the count range.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] val);
        logic [WIDTH:0] ext;
        logic [WIDTH:0] res;
        ext = {1'b0, val};
        res = (ext < MOD_EXT) ? ext : LAST;
        return res[WIDTH-1:0];
    endfunction

    // One count step in the requested direction. Past a limit, the counter
    // wraps or saturates, depending on the build.
    function automatic logic [WIDTH-1:0] count_step(input logic [WIDTH-1:0] cur,
                                                    input logic             dir);
        logic [WIDTH:0] ext;
        logic [WIDTH:0] res;
        ext = {1'b0, cur};
        if (dir == DIR_UP) begin
            res = (ext == LAST) ? AFTER_LAST : ext + ONE;
        end else begin
            res = (ext == ZERO) ? AFTER_ZERO : ext - ONE;
        end
        return res[WIDTH-1:0];
    endfunction

    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH:0]   q_ext;
    logic             at_limit;

    assign load_val = clamp_load(d);
    assign step_val = count_step(q, up);
    assign q_ext    = {1'b0, q};

    // Limit for the current direction: top when counting up, zero when counting down.
    assign at_limit = (up == DIR_DOWN) ? (q_ext == ZERO) : (q_ext == LAST);

    // tc is masked by reset and load, because neither of those edges performs a count step.
    assign tc = ~reset & en & ~load & at_limit;

    // Count register: reset has priority over load, load over enable; otherwise q holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= step_val;
        end
    end

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: a modulo-10 counter, a default
// modulo-16 counter, and a two-digit modulo-10 cascade. Expected values come
// from an integer reference model, are queued when stimulus is applied, and
// are popped after the clock edge. Honors COUNTER_SATURATE_EN like the design.
module tb_param_updown_counter;
    import counter_pkg::*;

    localparam int M = 10;
`ifdef COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] q;
        logic [3:0] q16;
        logic [3:0] lo;
        logic [3:0] hi;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up;
    logic       load;
    logic       c_en;
    logic [3:0] d;
    logic [3:0] q;
    logic [3:0] q16;
    logic [3:0] q_lo;
    logic [3:0] q_hi;
    logic       tc;
    logic       tc16;
    logic       tc_lo;
    logic       tc_hi;

    exp_t sb[$];
    int   passed;
    int   total;
    int   mq;
    int   m16;
    int   mlo;
    int   mhi;

    param_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .d(d),
        .q(q), .tc(tc)
    );

    param_updown_counter dut16 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .d(d),
        .q(q16), .tc(tc16)
    );

    param_updown_counter #(.WIDTH(4), .MODULUS(10)) stage_lo (
        .clk(clk), .reset(reset), .en(c_en), .up(up), .load(1'b0), .d(4'd0),
        .q(q_lo), .tc(tc_lo)
    );

    param_updown_counter #(.WIDTH(4), .MODULUS(10)) stage_hi (
        .clk(clk), .reset(reset), .en(tc_lo), .up(up), .load(1'b0), .d(4'd0),
        .q(q_hi), .tc(tc_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int m_next(int cur, bit r, bit l, bit e, bit u, int dv, int mod);
        if (r) return 0;
        if (l) return (dv < mod) ? dv : mod - 1;
        if (!e) return cur;
        if (u) begin
            if (SAT && cur == mod - 1) return cur;
            return (cur + 1) % mod;
        end
        if (SAT && cur == 0) return 0;
        return (cur + mod - 1) % mod;
    endfunction

    function automatic bit m_tc(int cur, bit r, bit l, bit e, bit u, int mod);
        if (r || l || !e) return 1'b0;
        return u ? (cur == mod - 1) : (cur == 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Apply one cycle of stimulus, check tc before the edge, and check q after it.
    task automatic step(input bit r, input bit l, input bit e, input bit u,
                        input int dv, input bit ce);
        exp_t ex;
        bit   t;
        bit   t16;
        bit   tlo;
        bit   thi;
        reset = r;
        load  = l;
        en    = e;
        up    = u;
        d     = 4'(dv);
        c_en  = ce;
        @(negedge clk);
        t   = m_tc(mq,  r, l,    e,   u, M);
        t16 = m_tc(m16, r, l,    e,   u, 16);
        tlo = m_tc(mlo, r, 1'b0, ce,  u, M);
        thi = m_tc(mhi, r, 1'b0, tlo, u, M);
        chk("tc",    32'(tc),    32'(t));
        chk("tc16",  32'(tc16),  32'(t16));
        chk("tc_lo", 32'(tc_lo), 32'(tlo));
        chk("tc_hi", 32'(tc_hi), 32'(thi));
        mq  = m_next(mq,  r, l,    e,   u, dv, M);
        m16 = m_next(m16, r, l,    e,   u, dv, 16);
        mhi = m_next(mhi, r, 1'b0, tlo, u, 0,  M);
        mlo = m_next(mlo, r, 1'b0, ce,  u, 0,  M);
        ex  = '{4'(mq), 4'(m16), 4'(mlo), 4'(mhi)};
        sb.push_back(ex);
        @(posedge clk);
        #1;
        ex = sb.pop_front();
        chk("q",    32'(q),    32'(ex.q));
        chk("q16",  32'(q16),  32'(ex.q16));
        chk("q_lo", 32'(q_lo), 32'(ex.lo));
        chk("q_hi", 32'(q_hi), 32'(ex.hi));
    endtask

    initial begin
        passed = 0;
        total  = 0;
        mq = 0; m16 = 0; mlo = 0; mhi = 0;
        reset = 1'b1; load = 1'b0; en = 1'b0; up = DIR_UP; d = 4'd0; c_en = 1'b0;

        // Reset state
        step(1, 0, 0, DIR_UP, 0, 0);
        chk("reset_q", 32'(q), 32'd0);

        // Count up 12 cycles: 0..9,0,1 (tc only at 9)
        repeat (12) step(0, 0, 1, DIR_UP, 0, 0);

        // Load 3, then count down 5: 3,2,1,0,9,8
        step(0, 1, 0, DIR_DOWN, 3, 0);
        chk("load3", 32'(q), 32'd3);
        repeat (5) step(0, 0, 1, DIR_DOWN, 0, 0);

        // Hold with en low
        repeat (2) step(0, 0, 0, DIR_DOWN, 0, 0);

        // Direction change while enabled, no dead cycle
        repeat (3) step(0, 0, 1, DIR_UP, 0, 0);
        repeat (3) step(0, 0, 1, DIR_DOWN, 0, 0);

        // Clamp on out-of-range load
        step(0, 1, 0, DIR_UP, 12, 0);
        chk("clamp", 32'(q), 32'd9);

        // Priority: load over en, reset over everything
        step(0, 1, 1, DIR_UP, 5, 0);
        chk("load_over_en", 32'(q), 32'd5);
        step(1, 1, 1, DIR_UP, 5, 0);
        chk("reset_over_load", 32'(q), 32'd0);

        // Load at the limit with en high masks tc; next edge wraps or holds
        step(0, 1, 1, DIR_UP, 9, 0);
        step(0, 0, 1, DIR_UP, 0, 0);

        // Reset mid-count, then resume from 0
        repeat (3) step(0, 0, 1, DIR_UP, 0, 0);
        step(1, 0, 1, DIR_UP, 0, 0);
        step(0, 0, 1, DIR_UP, 0, 0);
        chk("resume", 32'(q), 32'd1);

        // Up 15 from reset: wraps to 5, or saturates at 9 with tc held high
        step(1, 0, 0, DIR_UP, 0, 0);
        repeat (15) step(0, 0, 1, DIR_UP, 0, 0);
        chk("up15", 32'(q), SAT ? 32'd9 : 32'd5);
        step(0, 0, 1, DIR_UP, 0, 0);

        // Two-digit cascade: 25 counts from reset, then borrow back down
        step(1, 0, 0, DIR_UP, 0, 0);
        repeat (25) step(0, 0, 0, DIR_UP, 0, 1);
        chk("chain_hi", 32'(q_hi), SAT ? 32'd9 : 32'd2);
        chk("chain_lo", 32'(q_lo), SAT ? 32'd9 : 32'd5);
        repeat (6) step(0, 0, 0, DIR_DOWN, 0, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
